// File: rtl/wb_master_arbiter.sv
// Two-master, one-slave Wishbone B3 arbiter with round-robin grant and an ack watchdog.
// Grants are held until the owner drops cyc; a silent slave is terminated with an err pulse.
module wb_master_arbiter #(
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_DATA_WIDTH = 32,
  parameter int WB_SEL_WIDTH  = 4,
  parameter int TIMEOUT       = 255
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_n_i,
  // master 0
  input  logic [WB_ADDR_WIDTH-1:0] m0_wb_adr_i,
  input  logic [WB_DATA_WIDTH-1:0] m0_wb_dat_i,
  input  logic [WB_SEL_WIDTH-1:0]  m0_wb_sel_i,
  input  logic                     m0_wb_we_i,
  input  logic                     m0_wb_cyc_i,
  input  logic                     m0_wb_stb_i,
  input  logic [2:0]               m0_wb_cti_i,
  input  logic [1:0]               m0_wb_bte_i,
  output logic [WB_DATA_WIDTH-1:0] m0_wb_dat_o,
  output logic                     m0_wb_ack_o,
  output logic                     m0_wb_err_o,
  // master 1
  input  logic [WB_ADDR_WIDTH-1:0] m1_wb_adr_i,
  input  logic [WB_DATA_WIDTH-1:0] m1_wb_dat_i,
  input  logic [WB_SEL_WIDTH-1:0]  m1_wb_sel_i,
  input  logic                     m1_wb_we_i,
  input  logic                     m1_wb_cyc_i,
  input  logic                     m1_wb_stb_i,
  input  logic [2:0]               m1_wb_cti_i,
  input  logic [1:0]               m1_wb_bte_i,
  output logic [WB_DATA_WIDTH-1:0] m1_wb_dat_o,
  output logic                     m1_wb_ack_o,
  output logic                     m1_wb_err_o,
  // shared slave bus
  output logic [WB_ADDR_WIDTH-1:0] s_wb_adr_o,
  output logic [WB_DATA_WIDTH-1:0] s_wb_dat_o,
  output logic [WB_SEL_WIDTH-1:0]  s_wb_sel_o,
  output logic                     s_wb_we_o,
  output logic                     s_wb_cyc_o,
  output logic                     s_wb_stb_o,
  output logic [2:0]               s_wb_cti_o,
  output logic [1:0]               s_wb_bte_o,
  input  logic [WB_DATA_WIDTH-1:0] s_wb_dat_i,
  input  logic                     s_wb_ack_i,
  input  logic                     s_wb_err_i,
  output logic [1:0]               wb_gnt_o
);

  localparam logic [15:0] TERM_CNT = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_e;

  state_e      state_q;
  logic [1:0]  gnt_q;
  logic        last_q;      // 0: m0 owned last, 1: m1 owned last
  logic [15:0] wd_cnt_q, wd_cnt_d;
  logic        wd_err_q, wd_err_d;
  logic        wd_term;
  logic        owner_release;

  // Arbitration FSM; grant is registered so it changes only on a clock edge.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= IDLE;
      gnt_q   <= 2'b00;
      last_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (m0_wb_cyc_i && (!m1_wb_cyc_i || last_q)) begin
            state_q <= OWN0;
            gnt_q   <= 2'b01;
            last_q  <= 1'b0;
          end else if (m1_wb_cyc_i) begin
            state_q <= OWN1;
            gnt_q   <= 2'b10;
            last_q  <= 1'b1;
          end
        end
        OWN0: begin
          if (!m0_wb_cyc_i) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
          end
        end
        OWN1: begin
          if (!m1_wb_cyc_i) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= 2'b00;
        end
      endcase
    end
  end

  assign wb_gnt_o = gnt_q;

  always_comb begin
    s_wb_adr_o = '0;
    s_wb_dat_o = '0;
    s_wb_sel_o = '0;
    s_wb_we_o  = 1'b0;
    s_wb_cyc_o = 1'b0;
    s_wb_stb_o = 1'b0;
    s_wb_cti_o = 3'b000;
    s_wb_bte_o = 2'b00;
    if (gnt_q[0]) begin
      s_wb_adr_o = m0_wb_adr_i;
      s_wb_dat_o = m0_wb_dat_i;
      s_wb_sel_o = m0_wb_sel_i;
      s_wb_we_o  = m0_wb_we_i;
      s_wb_cyc_o = m0_wb_cyc_i;
      s_wb_stb_o = m0_wb_stb_i;
      s_wb_cti_o = m0_wb_cti_i;
      s_wb_bte_o = m0_wb_bte_i;
    end else if (gnt_q[1]) begin
      s_wb_adr_o = m1_wb_adr_i;
      s_wb_dat_o = m1_wb_dat_i;
      s_wb_sel_o = m1_wb_sel_i;
      s_wb_we_o  = m1_wb_we_i;
      s_wb_cyc_o = m1_wb_cyc_i;
      s_wb_stb_o = m1_wb_stb_i;
      s_wb_cti_o = m1_wb_cti_i;
      s_wb_bte_o = m1_wb_bte_i;
    end
  end

  // Watchdog: the count restarts on any response, idle strobe or hand-over.
  always_comb begin
    owner_release = (gnt_q[0] & ~m0_wb_cyc_i) | (gnt_q[1] & ~m1_wb_cyc_i);
    wd_term       = s_wb_stb_o & ~s_wb_ack_i & ~s_wb_err_i & (wd_cnt_q >= TERM_CNT);
    wd_err_d      = wd_term;
    if (!s_wb_stb_o || s_wb_ack_i || s_wb_err_i || owner_release || wd_term) begin
      wd_cnt_d = 16'd0;
    end else if (wd_cnt_q != 16'hFFFF) begin
      wd_cnt_d = wd_cnt_q + 16'd1;
    end else begin
      wd_cnt_d = wd_cnt_q;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      wd_cnt_q <= 16'd0;
      wd_err_q <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      wd_err_q <= wd_err_d;
    end
  end

  // Read data is broadcast; responses reach only the current owner.
  assign m0_wb_dat_o = s_wb_dat_i;
  assign m1_wb_dat_o = s_wb_dat_i;
  assign m0_wb_ack_o = s_wb_ack_i & gnt_q[0];
  assign m1_wb_ack_o = s_wb_ack_i & gnt_q[1];
  assign m0_wb_err_o = (s_wb_err_i | wd_err_q) & gnt_q[0];
  assign m1_wb_err_o = (s_wb_err_i | wd_err_q) & gnt_q[1];

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed bench for wb_master_arbiter: grant order, routing, bursts, watchdog, async reset.
module tb_wb_master_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] m0_adr, m0_dat_i, m0_dat_o, m1_adr, m1_dat_i, m1_dat_o;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_we, m0_cyc, m0_stb, m0_ack, m0_err;
  logic        m1_we, m1_cyc, m1_stb, m1_ack, m1_err;
  logic [2:0]  m0_cti, m1_cti, s_cti;
  logic [1:0]  m0_bte, m1_bte, s_bte;
  logic [31:0] s_adr, s_dat_o, s_dat_i;
  logic [3:0]  s_sel;
  logic        s_we, s_cyc, s_stb, s_ack, s_err;
  logic [1:0]  gnt;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  wb_master_arbiter #(
    .WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32), .WB_SEL_WIDTH(4), .TIMEOUT(8)
  ) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .m0_wb_adr_i(m0_adr), .m0_wb_dat_i(m0_dat_i), .m0_wb_sel_i(m0_sel), .m0_wb_we_i(m0_we),
    .m0_wb_cyc_i(m0_cyc), .m0_wb_stb_i(m0_stb), .m0_wb_cti_i(m0_cti), .m0_wb_bte_i(m0_bte),
    .m0_wb_dat_o(m0_dat_o), .m0_wb_ack_o(m0_ack), .m0_wb_err_o(m0_err),
    .m1_wb_adr_i(m1_adr), .m1_wb_dat_i(m1_dat_i), .m1_wb_sel_i(m1_sel), .m1_wb_we_i(m1_we),
    .m1_wb_cyc_i(m1_cyc), .m1_wb_stb_i(m1_stb), .m1_wb_cti_i(m1_cti), .m1_wb_bte_i(m1_bte),
    .m1_wb_dat_o(m1_dat_o), .m1_wb_ack_o(m1_ack), .m1_wb_err_o(m1_err),
    .s_wb_adr_o(s_adr), .s_wb_dat_o(s_dat_o), .s_wb_sel_o(s_sel), .s_wb_we_o(s_we),
    .s_wb_cyc_o(s_cyc), .s_wb_stb_o(s_stb), .s_wb_cti_o(s_cti), .s_wb_bte_o(s_bte),
    .s_wb_dat_i(s_dat_i), .s_wb_ack_i(s_ack), .s_wb_err_i(s_err),
    .wb_gnt_o(gnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    else pass_cnt++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_adr = '0; m0_dat_i = '0; m0_sel = 4'hF; m0_we = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    m0_cti = 3'b000; m0_bte = 2'b00;
    m1_adr = '0; m1_dat_i = '0; m1_sel = 4'hF; m1_we = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    m1_cti = 3'b000; m1_bte = 2'b00;
    s_dat_i = '0; s_ack = 1'b0; s_err = 1'b0;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Owner drops cyc for one cycle and re-requests; the other master is still waiting.
  task automatic hand_over(input int owner, input logic [1:0] exp_gnt);
    if (owner == 0) m0_cyc = 1'b0; else m1_cyc = 1'b0;
    tick();
    check("rr_gap_idle", gnt, 2'b00);
    if (owner == 0) m0_cyc = 1'b1; else m1_cyc = 1'b1;
    tick();
    check("rr_regrant", gnt, exp_gnt);
    $display("txn handover from m%0d -> gnt=%b", owner, gnt);
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    #2;
    check("rst_gnt", gnt, 2'b00);
    check("rst_s_cyc", s_cyc, 1'b0);
    check("rst_s_stb", s_stb, 1'b0);
    check("rst_m0_ack", m0_ack, 1'b0);
    check("rst_m0_err", m0_err, 1'b0);
    reset_dut();

    // m0 single read, slave acks in the third strobe cycle
    tick();
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h0000_0100;
    #1 check("t1_gnt_before_edge", gnt, 2'b00);
    tick();
    check("t1_gnt", gnt, 2'b01);
    check("t1_s_adr", s_adr, 32'h0000_0100);
    check("t1_s_stb", s_stb, 1'b1);
    tick();
    tick();
    s_ack = 1'b1; s_dat_i = 32'hDEAD_BEEF;
    #1;
    check("t1_m0_ack", m0_ack, 1'b1);
    check("t1_m0_dat", m0_dat_o, 32'hDEAD_BEEF);
    check("t1_m1_ack", m1_ack, 1'b0);
    $display("txn m0 read adr=0x100 dat=0x%08h", m0_dat_o);
    tick();
    s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    #1 check("t1_s_cyc_drop", s_cyc, 1'b0);
    tick();
    check("t1_gnt_idle", gnt, 2'b00);

    // simultaneous requests after reset, then round-robin alternation
    reset_dut();
    m0_cyc = 1'b1; m1_cyc = 1'b1;
    tick();
    check("t2_first_gnt", gnt, 2'b01);
    tick();
    check("t2_hold_gnt", gnt, 2'b01);
    hand_over(0, 2'b10);
    hand_over(1, 2'b01);
    hand_over(0, 2'b10);
    m0_cyc = 1'b0; m1_cyc = 1'b0;
    tick();
    tick();

    // m1 4-beat incrementing write burst with m0 requesting mid-burst
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_cti = 3'b010; m1_adr = 32'h200;
    tick();
    check("t3_gnt", gnt, 2'b10);
    for (int b = 0; b < 4; b++) begin
      m1_adr = 32'h200 + 32'(b * 4);
      m1_cti = (b == 3) ? 3'b111 : 3'b010;
      m1_dat_i = 32'hA5A5_0000 + 32'(b);
      s_ack = 1'b1;
      if (b == 1) begin
        m0_cyc = 1'b1; m0_stb = 1'b1;
      end
      #1;
      check("t3_m1_ack", m1_ack, 1'b1);
      check("t3_m0_ack", m0_ack, 1'b0);
      check("t3_s_adr", s_adr, 32'h200 + 32'(b * 4));
      check("t3_s_cti", s_cti, (b == 3) ? 3'b111 : 3'b010);
      $display("txn m1 burst beat %0d adr=0x%0h cti=%b", b, s_adr, s_cti);
      tick();
    end
    s_ack = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    #1;
    check("t3_gnt_held", gnt, 2'b10);
    check("t3_s_cyc", s_cyc, 1'b0);
    tick();
    check("t3_gap", gnt, 2'b00);
    tick();
    check("t3_m0_gnt", gnt, 2'b01);
    m0_cyc = 1'b0; m0_stb = 1'b0;
    tick();
    tick();

    // silent slave: err pulse 8 cycles after stb rises, then again 8 later
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h300;
    tick();
    check("t4_s_stb", s_stb, 1'b1);
    for (int i = 1; i <= 16; i++) begin
      tick();
      check("t4_wd_err", m0_err, (i == 8 || i == 16) ? 1'b1 : 1'b0);
      if (i == 8) check("t4_m1_err", m1_err, 1'b0);
    end
    $display("txn m0 timeout adr=0x300 two err pulses");
    m0_cyc = 1'b0; m0_stb = 1'b0;
    tick();
    tick();

    // ack lands exactly on the terminal count: ack wins
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h304;
    tick();
    repeat (7) tick();
    s_ack = 1'b1;
    #1;
    check("t5_ack", m0_ack, 1'b1);
    check("t5_err_same", m0_err, 1'b0);
    tick();
    s_ack = 1'b0;
    #1 check("t5_err_next", m0_err, 1'b0);
    $display("txn m0 late ack adr=0x304");
    m0_cyc = 1'b0; m0_stb = 1'b0;
    tick();
    tick();

    // async reset in the middle of an m1 write burst
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_cti = 3'b010; m1_adr = 32'h400;
    tick();
    check("t6_gnt", gnt, 2'b10);
    s_ack = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("t6_rst_s_cyc", s_cyc, 1'b0);
    check("t6_rst_s_stb", s_stb, 1'b0);
    check("t6_rst_gnt", gnt, 2'b00);
    check("t6_rst_m1_ack", m1_ack, 1'b0);
    s_ack = 1'b0; m0_cyc = 1'b1; m0_stb = 1'b1;
    #1 rst_n = 1'b1;
    tick();
    check("t6_post_rst_gnt", gnt, 2'b01);
    $display("txn reset during m1 burst, m0 granted after release");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/wb_master_arbiter.md
Name: wb_master_arbiter

Overview:
- Two-master, one-slave Wishbone B3 arbiter with round-robin grant and a per-transfer ack watchdog.
- Shares the single external memory bus between two internal masters (TX buffer-descriptor/DMA fetch on m0, RX DMA write-back on m1) of the Ethernet MAC.
- Sits between the MAC master ports and the system bus; it is the only driver of the shared master bus.

Parameters:
- WB_ADDR_WIDTH, 32, address width.
- WB_DATA_WIDTH, 32, data width.
- WB_SEL_WIDTH, 4, byte-select width, equal to WB_DATA_WIDTH/8.
- TIMEOUT, 255, slave wait cycles before the arbiter terminates a transfer with an error; legal range 2..65535.

Ports:
- wb_clk_i  in  1  bus clock; all logic is on the rising edge.
- wb_rst_n_i  in  1  asynchronous, active-low reset.
- m0_/m1_wb_adr_i  in, s_wb_adr_o  out  WB_ADDR_WIDTH  address.
- m0_/m1_wb_dat_i  in, s_wb_dat_o  out  WB_DATA_WIDTH  write data.
- m0_/m1_wb_sel_i  in, s_wb_sel_o  out  WB_SEL_WIDTH  byte select.
- m0_/m1_wb_we_i  in, s_wb_we_o  out  1  write enable.
- m0_/m1_wb_cyc_i  in, s_wb_cyc_o  out  1  cycle; also acts as the bus request.
- m0_/m1_wb_stb_i  in, s_wb_stb_o  out  1  strobe.
- m0_/m1_wb_cti_i  in, s_wb_cti_o  out  3  cycle type identifier.
- m0_/m1_wb_bte_i  in, s_wb_bte_o  out  2  burst type extension.
- s_wb_dat_i  in, m0_/m1_wb_dat_o  out  WB_DATA_WIDTH  read data, broadcast to both masters.
- s_wb_ack_i  in, m0_/m1_wb_ack_o  out  1  acknowledge, routed to the granted master only.
- s_wb_err_i  in, m0_/m1_wb_err_o  out  1  error, routed to the granted master only, OR'd with the watchdog error.
- wb_gnt_o  out  2  one-hot current grant; 2'b00 means idle.

Behaviour:
- Reset (asynchronous, wb_rst_n_i low), values immediate:
  - state=IDLE, wb_gnt_o=00, last_owner=m1 (so m0 wins the first tie), watchdog counter=0.
  - All s_* outputs 0.
  - All mN ack_o and err_o 0.
- FSM states: IDLE, OWN0, OWN1.
  - IDLE: only m0_cyc high -> OWN0; only m1_cyc high -> OWN1.
  - IDLE, both high: grant the master that is not last_owner.
  - Entering OWNn: last_owner<=n.
  - OWNn: stay while mN_wb_cyc_i=1; mN_wb_cyc_i=0 -> IDLE next cycle.
- No preemption: a grant holds through bursts and multi-beat cycles (cti 001/010) until the owner drops cyc.
- Arbitration latency:
  - cyc sampled high in IDLE at edge k -> grant and s_wb_cyc_o visible after edge k.
  - Owner drops cyc -> one IDLE cycle, then re-arbitration. Minimum gap between grants is 1 cycle.
- Datapath: s_* outputs combinationally muxed from the granted master.
  - Idle: s_wb_cyc_o and s_wb_stb_o are 0; the other s_* outputs are 0.
  - s_wb_cyc_o = granted mN_cyc_i; s_wb_stb_o = granted mN_stb_i (owner dropping cyc removes the slave cycle the same cycle).
- Response routing:
  - mN_ack_o = s_wb_ack_i & gnt[N]; likewise for err.
  - An ack or err arriving while idle is discarded.
- Watchdog:
  - Counter increments each cycle with s_wb_stb_o=1 and neither ack nor err.
  - Clears on ack, err, stb low, or grant change.
  - Count reaching TIMEOUT-1 with no ack that cycle -> one-cycle err pulse to the owner; counter clears.
  - ack and terminal count in the same cycle: ack wins, no err.
  - Counter width is 16 bits, saturating.
- Reset mid-transfer: bus is released immediately. Resumption is the master's responsibility.

Test Plan:
- Reset, then m0 single read at adr 0x0000_0100, slave acks 2 cycles after stb with dat 0xDEAD_BEEF -> wb_gnt_o=01 one cycle after cyc; m0_wb_dat_o=0xDEAD_BEEF with m0_ack_o; m1_ack_o stays 0.
- m0 and m1 assert cyc in the same cycle after reset -> m0 granted first. On m0 cyc drop: one IDLE cycle, then wb_gnt_o=10. Repeat with both held -> grants alternate 01,10,01,10.
- m1 4-beat incrementing burst (cti 010,010,010,111; bte 00) while m0 requests mid-burst -> all 4 acks go to m1; m0 is granted only after m1 drops cyc.
- Slave never acks, TIMEOUT=8 -> m0_err_o pulses once, exactly 8 cycles after stb rises; counter clears; a second 8-cycle wait gives a second pulse.
- Slave ack in the same cycle the counter reaches TIMEOUT-1 -> ack delivered, no err.
- wb_rst_n_i pulled low during an m1 write burst -> s_wb_cyc_o, s_wb_stb_o and wb_gnt_o go 0 without a clock edge. After release with both requesting, m0 is granted first.
